router_port_scheduler: RTL and testbench
========================================

// Module: router_port_scheduler
// PURPOSE
//  Clocked scheduler for one router output port. Arbitrates among 5 requesters:
//   [0..3] = input-port path computation units, [4] = local core.
//  Emits a 3-bit select code (000..100 = in1..in5) to the port's 5-way merge.
//  Gates issue on downstream buffer credits. One instance per output port (4 per node).
// PARAMETERS
//  NREQ      5   number of requesters; fixed at 5, matches 3-bit select encoding
//  CREDITS   4   downstream buffer depth; credit counter reset value and ceiling
//  CW        $clog2(CREDITS+1)   credit counter width (derived, do not override)
// PORTS
//  clk            in   1    clock; all state updates on posedge
//  rst            in   1    synchronous, active-high reset
//  req            in   5    per-requester request level; held high until granted
//  grant          out  5    one-hot grant pulse, 1 cycle, on the select handshake cycle
//  sel_valid      out  1    select code valid toward merge
//  sel_ready      in   1    merge accepts select code (handshake = sel_valid & sel_ready)
//  sel_code       out  3    winner index 3'b000..3'b100
//  credit_return  in   1    downstream freed one slot (1-cycle pulse)
//  credit_cnt     out  CW   current credits available
//  credit_ovf     out  1    sticky error: credit_return seen while credit_cnt==CREDITS
// BEHAVIOUR
//  Reset values: grant=0, sel_valid=0, sel_code=0, credit_cnt=CREDITS, credit_ovf=0,
//   RR pointer=0, FSM=IDLE. Reset mid-ISSUE abandons the pending select; no grant is issued.
//  FSM: IDLE, ISSUE.
//   IDLE: if |req && credit_cnt!=0, pick the winner by round-robin starting at the pointer.
//     Next cycle: sel_code=winner, sel_valid=1, FSM=ISSUE. Otherwise stay in IDLE.
//   ISSUE: hold sel_valid and sel_code stable until sel_ready.
//     On the handshake cycle: grant[winner]=1 for that cycle only; credit_cnt decrements;
//     pointer=(winner+1) mod 5; next cycle sel_valid=0, FSM=IDLE.
//  Latency: req to sel_valid = 1 cycle. Max throughput = 1 grant per 2 cycles.
//  RR: search order is ptr, ptr+1, ..., wrapping 4->0. The pointer moves only on a handshake.
//  Credits:
//   - Handshake and credit_return in the same cycle: credit_cnt is unchanged.
//   - credit_return alone: credit_cnt increments, saturating at CREDITS.
//   - credit_return at CREDITS: count held, credit_ovf set; only rst clears it.
//   - credit_cnt==0: no new arbitration. An ISSUE already in progress still completes
//     (its credit was checked at decision time).
//  Req drop before grant is a protocol violation. The winner in ISSUE is held regardless.
//  Req bits other than the winner may change freely. They are sampled only in IDLE.
//  sel_ready while sel_valid=0 is ignored.
// CONFIGURATION
//  SCHED_CORE_PRIO_EN defined:
//   - req[4] (local core) wins over all others whenever asserted in IDLE.
//   - The RR pointer covers only 0..3 (wrap 3->0) and is not advanced by core grants.
//  SCHED_CORE_PRIO_EN undefined: plain 5-way round-robin, as above.
// TESTING
//  1 rst, req=5'b00001, sel_ready=1 -> sel_valid cycle 1, sel_code=000, grant=00001 same
//    cycle, credit_cnt 4->3.
//  2 req=5'b11111 held, sel_ready=1, credit_return each grant -> sel_code sequence
//    000,001,010,011,100,000; grants every 2 cycles.
//  3 req=5'b00010, no credit_return, 5 attempts -> 4 grants, then credit_cnt=0 and
//    sel_valid stays 0; one credit_return -> 5th grant issued.
//  4 sel_ready=0 for 3 cycles while in ISSUE with sel_code=010 -> sel_valid/sel_code stable,
//    grant=0, credits unchanged; sel_ready=1 -> grant=00100.
//  5 credit_return and handshake in the same cycle at credit_cnt=2 -> stays 2;
//    credit_return at 4 -> credit_ovf=1, cnt=4.
//  6 rst asserted mid-ISSUE -> next cycle sel_valid=0, credit_cnt=4, ptr=0;
//    with SCHED_CORE_PRIO_EN and req=5'b10001 -> sel_code=100 first.

Source files
------------

// File: rtl/router_port_scheduler.sv
// Output-port scheduler: round-robin arbitration over 5 requesters, select/grant handshake
// toward the merge, gated by downstream credits. Optional macro SCHED_CORE_PRIO_EN gives req[4] priority.
module router_port_scheduler #(
    parameter int unsigned NREQ    = 5,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            sel_valid,
    input  logic            sel_ready,
    output logic [2:0]      sel_code,
    input  logic            credit_return,
    output logic [CW-1:0]   credit_cnt,
    output logic            credit_ovf
);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

`ifdef SCHED_CORE_PRIO_EN
    localparam int unsigned RR_N = NREQ - 1;
`else
    localparam int unsigned RR_N = NREQ;
`endif

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_ptr;
    logic [2:0]    w_ptr_next;
    logic [2:0]    r_sel_code;
    logic [2:0]    w_winner;
    logic          w_found;
    logic          w_start;
    logic          w_hs;
    logic [CW-1:0] r_credit;
    logic          r_ovf;

    always_comb begin : arb
        logic [2:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
`ifdef SCHED_CORE_PRIO_EN
        if (req[NREQ-1]) begin
            w_found  = 1'b1;
            w_winner = 3'(NREQ - 1);
        end
`endif
        for (int unsigned i = 0; i < RR_N; i++) begin
            idx = 3'((32'(r_ptr) + i) % RR_N);
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    // Handshake is suppressed during reset so an abandoned select never produces a grant.
    assign w_start = (r_state == ST_IDLE) && w_found && (r_credit != '0);
    assign w_hs    = (r_state == ST_ISSUE) && sel_ready && !rst;

    always_comb begin
        w_ptr_next = r_ptr;
`ifdef SCHED_CORE_PRIO_EN
        if (r_sel_code != 3'(NREQ - 1))
            w_ptr_next = (r_sel_code == 3'(RR_N - 1)) ? '0 : r_sel_code + 3'd1;
`else
        w_ptr_next = (r_sel_code == 3'(RR_N - 1)) ? '0 : r_sel_code + 3'd1;
`endif
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = ST_ISSUE;
            ST_ISSUE: if (w_hs)    w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_code <= '0;
            r_ptr      <= '0;
            r_credit   <= CW'(CREDITS);
            r_ovf      <= 1'b0;
        end else begin
            if (w_start) r_sel_code <= w_winner;
            if (w_hs)    r_ptr      <= w_ptr_next;
            // A credit consumed and returned in the same cycle cancels out.
            if (w_hs && !credit_return) begin
                r_credit <= r_credit - CW'(1);
            end else if (!w_hs && credit_return) begin
                if (r_credit == CW'(CREDITS)) r_ovf    <= 1'b1;
                else                          r_credit <= r_credit + CW'(1);
            end
        end
    end

    assign sel_valid  = (r_state == ST_ISSUE);
    assign sel_code   = r_sel_code;
    assign grant      = w_hs ? (NREQ'(1) << r_sel_code) : '0;
    assign credit_cnt = r_credit;
    assign credit_ovf = r_ovf;

endmodule

// File: tb/tb_router_port_scheduler.sv
// Scoreboard bench for router_port_scheduler: expected winners are queued when requests are
// driven and popped whenever a grant appears.
module tb_router_port_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] grant;
    logic       sel_valid;
    logic       sel_ready = 1'b0;
    logic [2:0] sel_code;
    logic       credit_return = 1'b0;
    logic [2:0] credit_cnt;
    logic       credit_ovf;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] sb_q[$];
    logic [2:0] mon_exp;
    logic [4:0] mon_grant;

    always #5 clk = ~clk;

    router_port_scheduler #(.NREQ(5), .CREDITS(4)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .sel_code(sel_code), .credit_return(credit_return),
        .credit_cnt(credit_cnt), .credit_ovf(credit_ovf)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; sel_ready = 1'b0; credit_return = 1'b0;
        sb_q.delete();
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL rst_sel_valid: got %b expected 0", sel_valid); end
        checks++; if (sel_code !== 3'd0) begin errors++; $display("FAIL rst_sel_code: got %0d expected 0", sel_code); end
        checks++; if (grant !== 5'd0) begin errors++; $display("FAIL rst_grant: got %b expected 00000", grant); end
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL rst_credit: got %0d expected 4", credit_cnt); end
        checks++; if (credit_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", credit_ovf); end
        step(1);
    endtask

    task automatic test_single();
        do_reset();
        sb_q.push_back(3'd0);
        req = 5'b00001; sel_ready = 1'b1;
        @(negedge clk);
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL single_lat0: got sel_valid=%b expected 0", sel_valid); end
        @(negedge clk);
        checks++; if (sel_valid !== 1'b1) begin errors++; $display("FAIL single_lat1: got sel_valid=%b expected 1", sel_valid); end
        checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL single_grant: got %b expected 00001", grant); end
        req = '0;
        step(1);
        checks++; if (credit_cnt !== 3'd3) begin errors++; $display("FAIL single_credit: got %0d expected 3", credit_cnt); end
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got sel_valid=%b expected 0", sel_valid); end
    endtask

    task automatic test_round_robin();
        int g = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
`ifdef SCHED_CORE_PRIO_EN
            sb_q.push_back(3'd4);
`else
            sb_q.push_back(3'(i % 5));
`endif
        end
        req = 5'b11111; sel_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            credit_return = (grant != '0);
            if (grant != '0) g++;
        end
        req = '0;
        step(1);
        credit_return = 1'b0;
        checks++; if (g !== 6) begin errors++; $display("FAIL rr_count: got %0d grants expected 6", g); end
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL rr_credit: got %0d expected 4", credit_cnt); end
        checks++; if (credit_ovf !== 1'b0) begin errors++; $display("FAIL rr_ovf: got %b expected 0", credit_ovf); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rr_pending: got %0d left expected 0", sb_q.size()); end
    endtask

    task automatic test_credit_exhaust();
        int g = 0;
        bit seen = 1'b0;
        do_reset();
        repeat (5) sb_q.push_back(3'd1);
        req = 5'b00010; sel_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (grant != '0) g++;
        end
        checks++; if (g !== 4) begin errors++; $display("FAIL exh_count: got %0d grants expected 4", g); end
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL exh_stall: got sel_valid=%b expected 0", sel_valid); end
        checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL exh_credit: got %0d expected 0", credit_cnt); end
        step(1);
        credit_return = 1'b1;
        step(1);
        credit_return = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) begin seen = 1'b1; req = '0; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL exh_fifth: got no grant expected one within 6 cycles"); end
        step(1);
        checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL exh_credit2: got %0d expected 0", credit_cnt); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL exh_pending: got %0d left expected 0", sb_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        sb_q.push_back(3'd2);
        req = 5'b00100; sel_ready = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (sel_valid !== 1'b1 || sel_code !== 3'd2) begin errors++; $display("FAIL bp_hold%0d: got valid=%b code=%0d expected 1/2", i, sel_valid, sel_code); end
            checks++; if (grant !== 5'd0 || credit_cnt !== 3'd4) begin errors++; $display("FAIL bp_idle%0d: got grant=%b cnt=%0d expected 00000/4", i, grant, credit_cnt); end
            step(1);
        end
        sel_ready = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL bp_grant: got %b expected 00100", grant); end
        req = '0;
        step(1);
        checks++; if (credit_cnt !== 3'd3) begin errors++; $display("FAIL bp_credit: got %0d expected 3", credit_cnt); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d left expected 0", sb_q.size()); end
    endtask

    task automatic test_credit_edges();
        int g = 0;
        do_reset();
        repeat (3) sb_q.push_back(3'd0);
        req = 5'b00001; sel_ready = 1'b1;
        for (int i = 0; i < 8 && g < 3; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g++;
                if (g == 3) begin credit_return = 1'b1; req = '0; end
            end
        end
        step(1);
        credit_return = 1'b0;
        checks++; if (g !== 3) begin errors++; $display("FAIL ce_count: got %0d grants expected 3", g); end
        checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL ce_same_cycle: got %0d expected 2", credit_cnt); end
        credit_return = 1'b1;
        step(2);
        credit_return = 1'b0;
        checks++; if (credit_cnt !== 3'd4 || credit_ovf !== 1'b0) begin errors++; $display("FAIL ce_refill: got cnt=%0d ovf=%b expected 4/0", credit_cnt, credit_ovf); end
        credit_return = 1'b1;
        step(1);
        credit_return = 1'b0;
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL ce_sat: got %0d expected 4", credit_cnt); end
        checks++; if (credit_ovf !== 1'b1) begin errors++; $display("FAIL ce_ovf: got %b expected 1", credit_ovf); end
        step(2);
        checks++; if (credit_ovf !== 1'b1) begin errors++; $display("FAIL ce_sticky: got %b expected 1", credit_ovf); end
    endtask

    task automatic test_reset_mid_issue();
        bit seen = 1'b0;
        req = 5'b00100; sel_ready = 1'b0;
        step(1);
        checks++; if (sel_valid !== 1'b1) begin errors++; $display("FAIL mid_issue: got sel_valid=%b expected 1", sel_valid); end
        rst = 1'b1; sel_ready = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 5'd0) begin errors++; $display("FAIL mid_nogrant: got %b expected 00000", grant); end
        step(1);
        rst = 1'b0; req = '0;
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", sel_valid); end
        checks++; if (credit_cnt !== 3'd4 || credit_ovf !== 1'b0) begin errors++; $display("FAIL mid_credit: got cnt=%0d ovf=%b expected 4/0", credit_cnt, credit_ovf); end
`ifdef SCHED_CORE_PRIO_EN
        sb_q.push_back(3'd4);
`else
        sb_q.push_back(3'd0);
`endif
        req = 5'b10001;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) begin seen = 1'b1; req = '0; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_regrant: got no grant expected one within 6 cycles"); end
        step(2);
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL mid_pending: got %0d left expected 0", sb_q.size()); end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (grant !== 5'd0) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got grant=%b code=%0d expected no grant", grant, sel_code);
                    end else begin
                        mon_exp   = sb_q.pop_front();
                        mon_grant = 5'b00001 << mon_exp;
                        if (sel_code !== mon_exp || grant !== mon_grant || sel_valid !== 1'b1) begin
                            errors++;
                            $display("FAIL sb_winner: got code=%0d grant=%b valid=%b expected code=%0d grant=%b valid=1",
                                     sel_code, grant, sel_valid, mon_exp, mon_grant);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_credit_exhaust();
        test_backpressure();
        test_credit_edges();
        test_reset_mid_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
